svnet_tree_arg_reduce: RTL

- Pipelined, parametrised tree reduction over COUNT lanes of WIDTH bits.
- Runtime-selectable min/max, signed or unsigned compare.
- Returns the winning value and its index.
- Also reduces across a multi-beat packet delimited by i_data_last, so one result covers COUNT*beats elements.
- Sits after convolution/pooling stages for arg-max classification and for min/max pooling over windows wider than one beat.

---
 rtl/svnet_pkg.sv | 45 ++++
 rtl/svnet_tree_arg_reduce_select.sv | 68 ++++++
 rtl/svnet_tree_arg_reduce.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/svnet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : svnet_pkg
// Description : Shared types and helpers for the svnet arg-reduce datapath:
//               min/max mode encoding, a strict "better than" compare and the
//               end-to-end latency of svnet_tree_arg_reduce.
// Revision    : 1.0 - initial release
// ============================================================================

// Beat-with-last to result-strobe latency for a given lane count.
`define SVNET_TREE_ARG_REDUCE_DELAY(count) ($clog2(count) + 2)

package svnet_pkg;

    typedef enum logic {
        SVNET_MODE_MIN = 1'b0,
        SVNET_MODE_MAX = 1'b1
    } svnet_reduce_mode_t;

    // Operands are handed over already sign- or zero-extended to this width.
    localparam int SVNET_MAX_WIDTH = 64;

    // Returns 1 only when a strictly beats b; equality never wins, which is
    // what lets the lower index keep ties everywhere in the datapath.
    function automatic logic svnet_better(
        input logic [SVNET_MAX_WIDTH-1:0] a,
        input logic [SVNET_MAX_WIDTH-1:0] b,
        input svnet_reduce_mode_t         mode,
        input logic                       signed_cmp
    );
        logic w_gt;
        logic w_lt;
        if (signed_cmp) begin
            w_gt = $signed(a) > $signed(b);
            w_lt = $signed(a) < $signed(b);
        end else begin
            w_gt = a > b;
            w_lt = a < b;
        end
        return (mode == SVNET_MODE_MAX) ? w_gt : w_lt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/svnet_tree_arg_reduce_select.sv
`default_nettype none
// ============================================================================
// Module      : svnet_arg_select_stage
// Description : One registered compare-select node of the reduction tree.
//               Port a always carries the lower lane indices, so b only wins
//               when it is strictly better.
// Revision    : 1.0 - initial release
// ============================================================================
module svnet_arg_select_stage
    import svnet_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int IDX_WIDTH = 4,
    parameter int SIGNED    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     i_a_val,
    input  logic [IDX_WIDTH-1:0] i_a_idx,
    input  logic                 i_a_valid,
    input  logic                 i_a_mode,
    input  logic [WIDTH-1:0]     i_b_val,
    input  logic [IDX_WIDTH-1:0] i_b_idx,
    input  logic                 i_b_valid,
    input  logic                 i_b_mode,
    output logic [WIDTH-1:0]     o_val,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_valid,
    output logic                 o_mode
);

    logic [SVNET_MAX_WIDTH-1:0] w_a_ext;
    logic [SVNET_MAX_WIDTH-1:0] w_b_ext;
    logic                       w_mode;
    logic                       w_b_wins;

    // Extend both operands to the common compare width and pick the winner.
    always_comb begin
        w_a_ext              = {SVNET_MAX_WIDTH{(SIGNED != 0) && i_a_val[WIDTH-1]}};
        w_a_ext[WIDTH-1:0]   = i_a_val;
        w_b_ext              = {SVNET_MAX_WIDTH{(SIGNED != 0) && i_b_val[WIDTH-1]}};
        w_b_ext[WIDTH-1:0]   = i_b_val;
        w_mode               = i_a_valid ? i_a_mode : i_b_mode;
        w_b_wins             = i_b_valid &&
                               (!i_a_valid ||
                                svnet_better(w_b_ext, w_a_ext,
                                             svnet_reduce_mode_t'(w_mode),
                                             SIGNED != 0));
    end

    // Register the selected tuple so every tree level costs one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_val   <= '0;
            o_idx   <= '0;
            o_valid <= 1'b0;
            o_mode  <= 1'b0;
        end else begin
            o_val   <= w_b_wins ? i_b_val : i_a_val;
            o_idx   <= w_b_wins ? i_b_idx : i_a_idx;
            o_valid <= i_a_valid | i_b_valid;
            o_mode  <= w_mode;
        end
    end

endmodule

`default_nettype wire

// File: rtl/svnet_tree_arg_reduce.sv
`default_nettype none
// ============================================================================
// Module      : svnet_tree_arg_reduce
// Description : Pipelined arg-min/arg-max over COUNT lanes, accumulated across
//               a multi-beat packet. Input register, $clog2(COUNT) tree
//               levels, then the accumulate/output register.
// Revision    : 1.0 - initial release
// ============================================================================
module svnet_tree_arg_reduce
    import svnet_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int COUNT     = 4,
    parameter int MAX_BEATS = 16,
    parameter int SIGNED    = 1,
    parameter int IDX_WIDTH = (COUNT * MAX_BEATS > 1) ? $clog2(COUNT * MAX_BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_data_valid,
    input  logic                   i_data_last,
    input  logic                   i_mode,
    input  logic [COUNT*WIDTH-1:0] i_data,
    output logic                   o_data_valid,
    output logic [WIDTH-1:0]       o_data,
    output logic [IDX_WIDTH-1:0]   o_index,
    output logic                   o_overflow
);

    localparam int c_LEVELS = (COUNT > 1) ? $clog2(COUNT) : 0;
    localparam int c_BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    // Live node count at a given tree level (odd nodes round up).
    function automatic int nodes_at(input int lvl);
        int n;
        n = COUNT;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // ------------------------------------------------------------------ input
    logic [COUNT*WIDTH-1:0] r_in_data;
    logic                   r_in_valid;
    logic                   r_in_last;
    logic                   r_in_mode;
    logic                   r_in_packet;
    logic                   r_mode_lat;
    logic                   w_beat_mode;

    assign w_beat_mode = r_in_packet ? r_mode_lat : i_mode;

    // Capture the beat and pin the packet's mode on its first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_data   <= '0;
            r_in_valid  <= 1'b0;
            r_in_last   <= 1'b0;
            r_in_mode   <= 1'b0;
            r_in_packet <= 1'b0;
            r_mode_lat  <= 1'b0;
        end else begin
            r_in_valid <= i_data_valid;
            r_in_last  <= i_data_valid & i_data_last;
            if (i_data_valid) begin
                r_in_data   <= i_data;
                r_in_mode   <= w_beat_mode;
                r_in_packet <= !i_data_last;
                if (!r_in_packet) r_mode_lat <= i_mode;
            end
        end
    end

    // ------------------------------------------------------------------- tree
    logic [WIDTH-1:0]     w_lv_val   [0:c_LEVELS][0:COUNT-1];
    logic [IDX_WIDTH-1:0] w_lv_idx   [0:c_LEVELS][0:COUNT-1];
    logic                 w_lv_valid [0:c_LEVELS][0:COUNT-1];
    logic                 w_lv_mode  [0:c_LEVELS][0:COUNT-1];
    logic                 w_lv_last  [0:c_LEVELS];

    assign w_lv_last[0] = r_in_last;

    for (genvar j = 0; j < COUNT; j++) begin : g_lane
        assign w_lv_val[0][j]   = r_in_data[j*WIDTH +: WIDTH];
        assign w_lv_idx[0][j]   = IDX_WIDTH'(j);
        assign w_lv_valid[0][j] = r_in_valid;
        assign w_lv_mode[0][j]  = r_in_mode;
    end

    for (genvar l = 0; l < c_LEVELS; l++) begin : g_level
        localparam int c_IN_N  = nodes_at(l);
        localparam int c_OUT_N = nodes_at(l + 1);

        logic r_last;

        // Last flag rides alongside the tree so it meets its beat's result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_last <= 1'b0;
            else        r_last <= w_lv_last[l];
        end
        assign w_lv_last[l+1] = r_last;

        for (genvar j = 0; j < COUNT; j++) begin : g_node
            if (j < c_OUT_N && (2 * j + 1) < c_IN_N) begin : g_pair
                svnet_arg_select_stage #(
                    .WIDTH     (WIDTH),
                    .IDX_WIDTH (IDX_WIDTH),
                    .SIGNED    (SIGNED)
                ) u_stage (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .i_a_val   (w_lv_val[l][2*j]),
                    .i_a_idx   (w_lv_idx[l][2*j]),
                    .i_a_valid (w_lv_valid[l][2*j]),
                    .i_a_mode  (w_lv_mode[l][2*j]),
                    .i_b_val   (w_lv_val[l][2*j+1]),
                    .i_b_idx   (w_lv_idx[l][2*j+1]),
                    .i_b_valid (w_lv_valid[l][2*j+1]),
                    .i_b_mode  (w_lv_mode[l][2*j+1]),
                    .o_val     (w_lv_val[l+1][j]),
                    .o_idx     (w_lv_idx[l+1][j]),
                    .o_valid   (w_lv_valid[l+1][j]),
                    .o_mode    (w_lv_mode[l+1][j])
                );
            end else if (j < c_OUT_N) begin : g_pass
                logic [WIDTH-1:0]     r_val;
                logic [IDX_WIDTH-1:0] r_idx;
                logic                 r_valid;
                logic                 r_mode;

                // Unpaired node: delay by one stage to stay aligned with pairs.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_val   <= '0;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_mode  <= 1'b0;
                    end else begin
                        r_val   <= w_lv_val[l][2*j];
                        r_idx   <= w_lv_idx[l][2*j];
                        r_valid <= w_lv_valid[l][2*j];
                        r_mode  <= w_lv_mode[l][2*j];
                    end
                end
                assign w_lv_val[l+1][j]   = r_val;
                assign w_lv_idx[l+1][j]   = r_idx;
                assign w_lv_valid[l+1][j] = r_valid;
                assign w_lv_mode[l+1][j]  = r_mode;
            end else begin : g_unused
                assign w_lv_val[l+1][j]   = '0;
                assign w_lv_idx[l+1][j]   = '0;
                assign w_lv_valid[l+1][j] = 1'b0;
                assign w_lv_mode[l+1][j]  = 1'b0;
            end

            if (j > 0 && j < c_OUT_N) begin : g_chk
                a_valid_agree: assert property (@(posedge clk) disable iff (!rst_n)
                    w_lv_valid[l+1][j] == w_lv_valid[l+1][0]);
            end
        end
    end

    // ------------------------------------------------------------ accumulator
    logic [WIDTH-1:0]           w_t_val;
    logic [IDX_WIDTH-1:0]       w_t_idx;
    logic                       w_t_valid;
    logic                       w_t_mode;
    logic                       w_t_last;
    logic [WIDTH-1:0]           r_acc_val;
    logic [IDX_WIDTH-1:0]       r_acc_idx;
    logic                       r_acc_active;
    logic [c_BEAT_W-1:0]        r_beat_cnt;
    logic                       r_ovf;
    logic [SVNET_MAX_WIDTH-1:0] w_t_ext;
    logic [SVNET_MAX_WIDTH-1:0] w_acc_ext;
    logic [IDX_WIDTH-1:0]       w_cand_idx;
    logic                       w_take;
    logic                       w_beat_full;
    logic [WIDTH-1:0]           w_next_val;
    logic [IDX_WIDTH-1:0]       w_next_idx;

    assign w_t_val   = w_lv_val[c_LEVELS][0];
    assign w_t_idx   = w_lv_idx[c_LEVELS][0];
    assign w_t_valid = w_lv_valid[c_LEVELS][0];
    assign w_t_mode  = w_lv_mode[c_LEVELS][0];
    assign w_t_last  = w_lv_last[c_LEVELS];

    // Decide whether this beat's winner displaces the running packet winner.
    always_comb begin
        w_t_ext              = {SVNET_MAX_WIDTH{(SIGNED != 0) && w_t_val[WIDTH-1]}};
        w_t_ext[WIDTH-1:0]   = w_t_val;
        w_acc_ext            = {SVNET_MAX_WIDTH{(SIGNED != 0) && r_acc_val[WIDTH-1]}};
        w_acc_ext[WIDTH-1:0] = r_acc_val;
        w_cand_idx  = IDX_WIDTH'(r_beat_cnt) * IDX_WIDTH'(COUNT) + w_t_idx;
        w_beat_full = (r_beat_cnt == c_BEAT_W'(MAX_BEATS - 1));
        w_take      = !r_acc_active ||
                      svnet_better(w_t_ext, w_acc_ext,
                                   svnet_reduce_mode_t'(w_t_mode), SIGNED != 0);
        w_next_val  = w_take ? w_t_val    : r_acc_val;
        w_next_idx  = w_take ? w_cand_idx : r_acc_idx;
    end

    // Accumulate across beats; publish and clear packet state on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_val    <= '0;
            r_acc_idx    <= '0;
            r_acc_active <= 1'b0;
            r_beat_cnt   <= '0;
            r_ovf        <= 1'b0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_index      <= '0;
            o_overflow   <= 1'b0;
        end else begin
            o_data_valid <= w_t_valid & w_t_last;
            if (w_t_valid) begin
                r_acc_val <= w_next_val;
                r_acc_idx <= w_next_idx;
                if (w_t_last) begin
                    r_acc_active <= 1'b0;
                    r_beat_cnt   <= '0;
                    r_ovf        <= 1'b0;
                    o_data       <= w_next_val;
                    o_index      <= w_next_idx;
                    o_overflow   <= r_ovf;
                end else begin
                    r_acc_active <= 1'b1;
                    r_ovf        <= r_ovf | w_beat_full;
                    if (!w_beat_full) r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    // Mode changes inside a packet and stray last flags are ignored; flag them.
    c_mode_change: cover property (@(posedge clk) disable iff (!rst_n)
        i_data_valid && r_in_packet && (i_mode != r_mode_lat));
    c_stray_last: cover property (@(posedge clk) disable iff (!rst_n)
        i_data_last && !i_data_valid);

endmodule

`default_nettype wire
